// File: rtl/mmacc_tile_streamer.sv
// Streams a B tile and A rows, emitting one unsigned dot product per B column.
// A row result appears CHUNK_HEIGHT cycles after its last element; out_ready low freezes the result.
module mmacc_tile_streamer #(
  parameter int DATA_WIDTH   = 32,
  parameter int CHUNK_WIDTH  = 8,
  parameter int CHUNK_HEIGHT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    in_is_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*DATA_WIDTH-1:0] out_data,
  output logic                    out_last,
  output logic                    b_loaded,
  output logic                    busy
);

  localparam int AW = (CHUNK_HEIGHT > 1) ? $clog2(CHUNK_HEIGHT) : 1;
  localparam int CW = (CHUNK_WIDTH > 1) ? $clog2(CHUNK_WIDTH) : 1;
  localparam int PW = 2 * DATA_WIDTH;
  localparam logic [AW-1:0] ROW_LAST = AW'(CHUNK_HEIGHT - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(CHUNK_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_MAC,
    ST_DRAIN
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   a_count_q, a_count_d;
  logic [AW-1:0]   i_q, i_d;
  logic [AW-1:0]   b_row_q, b_row_d;
  logic [CW-1:0]   b_col_q, b_col_d;
  logic [CW-1:0]   c_q, c_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic            b_loaded_q, b_loaded_d;
  logic            a_we;
  logic            b_we;
  logic [PW-1:0]   product;

  logic [DATA_WIDTH-1:0] a_mem [CHUNK_HEIGHT];
  logic [DATA_WIDTH-1:0] b_mem [CHUNK_WIDTH][CHUNK_HEIGHT];

  assign product = PW'(a_mem[i_q]) * PW'(b_mem[c_q][i_q]);

  always_comb begin
    state_d    = state_q;
    a_count_d  = a_count_q;
    i_d        = i_q;
    b_row_d    = b_row_q;
    b_col_d    = b_col_q;
    c_d        = c_q;
    acc_d      = acc_q;
    b_loaded_d = b_loaded_q;
    in_ready   = 1'b0;
    a_we       = 1'b0;
    b_we       = 1'b0;

    unique case (state_q)
      ST_LOAD: begin
        // B may only be replaced between rows; A needs a complete tile.
        in_ready = in_is_b ? (a_count_q == '0) : b_loaded_q;
        if (in_valid && in_ready) begin
          if (in_is_b) begin
            b_we = 1'b1;
            if (b_row_q == ROW_LAST) begin
              b_row_d = '0;
              if (b_col_q == COL_LAST) begin
                b_col_d    = '0;
                b_loaded_d = 1'b1;
              end else begin
                b_col_d    = b_col_q + CW'(1);
                b_loaded_d = 1'b0;
              end
            end else begin
              b_row_d    = b_row_q + AW'(1);
              b_loaded_d = 1'b0;
            end
          end else begin
            a_we = 1'b1;
            if (a_count_q == ROW_LAST) begin
              a_count_d = '0;
              c_d       = '0;
              acc_d     = '0;
              i_d       = '0;
              state_d   = ST_MAC;
            end else begin
              a_count_d = a_count_q + AW'(1);
            end
          end
        end
      end

      ST_MAC: begin
        acc_d = acc_q + product;
        if (i_q == ROW_LAST) begin
          i_d     = '0;
          state_d = ST_DRAIN;
        end else begin
          i_d = i_q + AW'(1);
        end
      end

      ST_DRAIN: begin
        if (out_ready) begin
          if (c_q == COL_LAST) begin
            state_d = ST_LOAD;
          end else begin
            c_d     = c_q + CW'(1);
            acc_d   = '0;
            i_d     = '0;
            state_d = ST_MAC;
          end
        end
      end

      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_LOAD;
      a_count_q  <= '0;
      i_q        <= '0;
      b_row_q    <= '0;
      b_col_q    <= '0;
      c_q        <= '0;
      acc_q      <= '0;
      b_loaded_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_count_q  <= a_count_d;
      i_q        <= i_d;
      b_row_q    <= b_row_d;
      b_col_q    <= b_col_d;
      c_q        <= c_d;
      acc_q      <= acc_d;
      b_loaded_q <= b_loaded_d;
    end
  end

  // Operand storage is left unreset; b_loaded gates every use of it.
  always_ff @(posedge clk) begin
    if (a_we) begin
      a_mem[a_count_q] <= in_data;
    end
    if (b_we) begin
      b_mem[b_col_q][b_row_q] <= in_data;
    end
  end

  assign out_valid = (state_q == ST_DRAIN);
  assign out_data  = out_valid ? acc_q : '0;
  assign out_last  = out_valid && (c_q == COL_LAST);
  assign b_loaded  = b_loaded_q;
  assign busy      = (state_q != ST_LOAD);

endmodule

// File: tb/tb_mmacc_tile_streamer.sv
// Scoreboard bench for mmacc_tile_streamer with a 2x2 tile of 8-bit operands.
module tb_mmacc_tile_streamer;

  localparam int DW = 8;
  localparam int CW = 2;
  localparam int CH = 2;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_is_b;
  logic          out_valid;
  logic          out_ready;
  logic [2*DW-1:0] out_data;
  logic          out_last;
  logic          b_loaded;
  logic          busy;

  typedef struct {
    logic [2*DW-1:0] data;
    logic            last;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  mmacc_tile_streamer #(
    .DATA_WIDTH  (DW),
    .CHUNK_WIDTH (CW),
    .CHUNK_HEIGHT(CH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_is_b  (in_is_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .b_loaded (b_loaded),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, required finish before 100us");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2*DW-1:0] d, input logic l);
    exp_t e;
    e.data = d;
    e.last = l;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic is_b, input logic [DW-1:0] d);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_is_b  = is_b;
    in_data  = d;
    #1;
    while (!in_ready && waited < 50) begin
      tick();
      waited++;
    end
    chk("send_accept", {31'd0, in_ready}, 32'd1);
    if (in_ready) tick();
    in_valid = 1'b0;
  endtask

  task automatic load_b(input logic [DW-1:0] b0, input logic [DW-1:0] b1,
                        input logic [DW-1:0] b2, input logic [DW-1:0] b3);
    send(1'b1, b0);
    send(1'b1, b1);
    send(1'b1, b2);
    send(1'b1, b3);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    chk("drain_done", {31'd0, (n < 200)}, 32'd1);
  endtask

  // Scoreboard monitor: pops on every handshake, polices idle outputs.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_result: got %0d last=%0d required no result", out_data, out_last);
        end else begin
          e = exp_q.pop_front();
          n_cmp++;
          if (out_data !== e.data || out_last !== e.last) begin
            n_fail++;
            $display("FAIL result: got %0d last=%0d required %0d last=%0d",
                     out_data, out_last, e.data, e.last);
          end
        end
      end
      if (!out_valid) begin
        n_cmp++;
        if (out_data !== '0 || out_last !== 1'b0) begin
          n_fail++;
          $display("FAIL idle_outputs: got data=%0d last=%0d required 0 0", out_data, out_last);
        end
      end
    end
  end

  initial begin
    int seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_is_b   = 1'b1;
    in_data   = '0;
    out_ready = 1'b1;

    // Reset state
    tick();
    tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {16'd0, out_data}, 32'd0);
    chk("rst_b_loaded", {31'd0, b_loaded}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    in_is_b = 1'b1;
    #1;
    chk("rst_ready_b", {31'd0, in_ready}, 32'd1);
    in_is_b = 1'b0;
    #1;
    chk("rst_ready_a", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("post_rst_ready_a", {31'd0, in_ready}, 32'd0);

    // Basic compute: [5,6]x[1,2]=17, [5,6]x[3,4]=39
    load_b(8'd1, 8'd2, 8'd3, 8'd4);
    chk("b_loaded_after_tile", {31'd0, b_loaded}, 32'd1);
    push(16'd17, 1'b0);
    push(16'd39, 1'b1);
    send(1'b0, 8'd5);
    send(1'b0, 8'd6);
    chk("lat_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("lat_cycle1_valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk("lat_cycle2_valid", {31'd0, out_valid}, 32'd1);
    wait_idle();
    in_is_b = 1'b0;
    #1;
    chk("next_row_ready", {31'd0, in_ready}, 32'd1);

    // Wrap: 2*255*255 = 130050 mod 65536 = 64514
    send(1'b1, 8'd255);
    chk("b_reload_clears", {31'd0, b_loaded}, 32'd0);
    send(1'b1, 8'd255);
    send(1'b1, 8'd255);
    send(1'b1, 8'd255);
    chk("b_reloaded", {31'd0, b_loaded}, 32'd1);
    push(16'd64514, 1'b0);
    push(16'd64514, 1'b1);
    send(1'b0, 8'd255);
    send(1'b0, 8'd255);
    wait_idle();

    // Backpressure
    load_b(8'd1, 8'd2, 8'd3, 8'd4);
    out_ready = 1'b0;
    push(16'd17, 1'b0);
    push(16'd39, 1'b1);
    send(1'b0, 8'd5);
    send(1'b0, 8'd6);
    seen = 0;
    while (!out_valid && seen < 20) begin
      tick();
      seen++;
    end
    chk("bp_valid_rise", {31'd0, out_valid}, 32'd1);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_hold_data", {16'd0, out_data}, 32'd17);
      chk("bp_hold_last", {31'd0, out_last}, 32'd0);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_after_hs0", {31'd0, out_valid}, 32'd0);
    tick();
    chk("bp_after_hs1", {31'd0, out_valid}, 32'd0);
    tick();
    chk("bp_after_hs2", {31'd0, out_valid}, 32'd1);
    wait_idle();

    // Stalls
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("stall_b_unloaded", {31'd0, b_loaded}, 32'd0);
    in_valid = 1'b1;
    in_is_b  = 1'b0;
    in_data  = 8'd5;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_a_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_a_busy", {31'd0, busy}, 32'd0);
    end
    in_valid = 1'b0;
    load_b(8'd1, 8'd2, 8'd3, 8'd4);
    send(1'b0, 8'd5);
    in_valid = 1'b1;
    in_is_b  = 1'b1;
    in_data  = 8'd9;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_b_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    chk("stall_b_keeps_tile", {31'd0, b_loaded}, 32'd1);
    push(16'd17, 1'b0);
    push(16'd39, 1'b1);
    send(1'b0, 8'd6);
    wait_idle();

    // Mid-operation reset
    send(1'b0, 8'd5);
    send(1'b0, 8'd6);
    tick();
    chk("abort_in_mac", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_b_loaded", {31'd0, b_loaded}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    tick();
    rst  = 1'b0;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("abort_no_valid", seen, 32'd0);
    chk("abort_b_still_clear", {31'd0, b_loaded}, 32'd0);
    load_b(8'd1, 8'd2, 8'd3, 8'd4);
    push(16'd17, 1'b0);
    push(16'd39, 1'b1);
    send(1'b0, 8'd5);
    send(1'b0, 8'd6);
    wait_idle();

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mmacc_tile_streamer.md
MMACC_TILE_STREAMER -- requirements
Module: mmacc_tile_streamer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, element width of A and B operands.
REQ-002 SHALL have parameter CHUNK_WIDTH, default 8, number of B columns, which equals the number of results per A row.
REQ-003 SHALL have parameter CHUNK_HEIGHT, default 8, elements per A row and per B column.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  in_data/in_is_b valid.
REQ-007 SHALL have port in_ready  output  1  element accepted on clk edge when in_valid && in_ready.
REQ-008 SHALL have port in_data  input  DATA_WIDTH  operand element, unsigned.
REQ-009 SHALL have port in_is_b  input  1  1 = B tile element, 0 = A row element.
REQ-010 SHALL have port out_valid  output  1  out_data/out_last valid.
REQ-011 SHALL have port out_ready  input  1  result consumed on clk edge when out_valid && out_ready.
REQ-012 SHALL have port out_data  output  2*DATA_WIDTH  one dot-product result.
REQ-013 SHALL have port out_last  output  1  marks result for column CHUNK_WIDTH-1.
REQ-014 SHALL have port b_loaded  output  1  complete B tile held.
REQ-015 SHALL have port busy  output  1  high in MAC or DRAIN state.

Function
REQ-016 SHALL implement the states LOAD, MAC and DRAIN.
REQ-017 In LOAD, in_ready SHALL be 1 when (in_is_b && a_count==0) || (!in_is_b && b_loaded), else 0; in_ready SHALL be 0 in MAC and DRAIN.
REQ-018 Accepted B elements SHALL fill B[j][i] column-major via b_count: element k goes to j = k / CHUNK_HEIGHT, i = k % CHUNK_HEIGHT.
REQ-019 On acceptance of B element k = CHUNK_WIDTH*CHUNK_HEIGHT-1, b_count SHALL wrap to 0 and b_loaded SHALL be set on the same edge.
REQ-020 Acceptance of any B element while b_loaded=1 SHALL clear b_loaded and start a new tile at k=0, overwriting the old tile.
REQ-021 The B tile SHALL persist across any number of A rows.
REQ-022 Accepted A elements SHALL fill A[a_count], with a_count counting 0..CHUNK_HEIGHT-1.
REQ-023 On acceptance of A element CHUNK_HEIGHT-1, the block SHALL move LOAD -> MAC with column c=0, acc=0, i=0, and a_count cleared.
REQ-024 In MAC, the block SHALL perform one multiply-accumulate per cycle: acc <= acc + A[i]*B[c][i], with i counting 0..CHUNK_HEIGHT-1.
REQ-025 After the i=CHUNK_HEIGHT-1 update, MAC SHALL move to DRAIN.
REQ-026 Latency SHALL be as follows: out_valid rises exactly CHUNK_HEIGHT cycles after the edge accepting the last A element.
REQ-027 In DRAIN, out_valid SHALL be 1, out_data SHALL equal acc, and out_last SHALL equal (c==CHUNK_WIDTH-1).
REQ-028 While out_ready=0 in DRAIN, out_data and out_last SHALL hold stable.
REQ-029 On a DRAIN handshake with c<CHUNK_WIDTH-1, the block SHALL set c<=c+1, acc<=0, i<=0 and return to MAC.
REQ-030 On a DRAIN handshake with c=CHUNK_WIDTH-1, the block SHALL return to LOAD.
REQ-031 The next A row SHALL be acceptable on the cycle after the final handshake.
REQ-032 Arithmetic SHALL be unsigned; products SHALL be 2*DATA_WIDTH wide and the accumulator SHALL wrap modulo 2^(2*DATA_WIDTH) with no saturation or overflow flag.
REQ-033 out_valid SHALL be 0 outside DRAIN; out_data SHALL be 0 when out_valid=0.
REQ-034 A B element presented while a_count!=0 SHALL stall with in_ready=0 and SHALL NOT corrupt the partial A row.
REQ-035 An A element presented while b_loaded=0 SHALL stall with in_ready=0 and SHALL NOT be dropped.

Reset
REQ-036 When rst is asserted, the block SHALL immediately enter LOAD and clear a_count, b_count, c, i and acc to 0.
REQ-037 During reset, b_loaded, out_valid, out_data, out_last and busy SHALL be 0.
REQ-038 B/A storage contents need not be cleared by reset, but SHALL be unusable until a full B tile is reloaded, because b_loaded=0.
REQ-039 Reset asserted during MAC or DRAIN SHALL abort the row; no further out_valid SHALL occur until a new B tile and A row are loaded.

Verification (bench parameters DATA_WIDTH=8, CHUNK_WIDTH=2, CHUNK_HEIGHT=2)
REQ-040 The bench SHALL check reset: pulse rst -> out_valid=0, out_data=0, b_loaded=0, busy=0; with in_is_b=1, in_ready=1; with in_is_b=0, in_ready=0.
REQ-041 The bench SHALL check basic compute: B stream 1,2,3,4 (B[0]=[1,2], B[1]=[3,4]), then A stream 5,6 -> out_valid 2 cycles after A last; results 17 (out_last=0) then 39 (out_last=1); then in_ready=1 for A.
REQ-042 The bench SHALL check wrap: B all 255, A=[255,255] -> both results 64514 (130050 mod 65536).
REQ-043 The bench SHALL check backpressure: hold out_ready=0 for 10 cycles in DRAIN -> out_data=17 stable, out_valid=1; release -> second result follows CHUNK_HEIGHT cycles after handshake.
REQ-044 The bench SHALL check stalls: A element with b_loaded=0 -> in_ready=0; after one A element accepted, B element -> in_ready=0 and the completed row result is unaffected.
REQ-045 The bench SHALL check mid-operation reset: assert rst one cycle into MAC -> out_valid never rises and b_loaded=0; reload B 1,2,3,4 and A 5,6 -> 17, 39.
